// File: rtl/controller_pkg.sv
// Shared definitions for the accumulator-CPU control decoder: opcode classes,
// ALU and accumulator op encodings, and the registered control bundle.
package controller_pkg;

  // Opcode classes carried in op[5:3]
  localparam logic [2:0] CLS_RALU = 3'b000;
  localparam logic [2:0] CLS_IALU = 3'b001;
  localparam logic [2:0] CLS_BR   = 3'b010;
  localparam logic [2:0] CLS_ACC  = 3'b011;
  localparam logic [2:0] CLS_LD   = 3'b100;
  localparam logic [2:0] CLS_ST   = 3'b101;
  localparam logic [2:0] CLS_RSV  = 3'b110;
  localparam logic [2:0] CLS_JMP  = 3'b111;

  // All-zero opcode is the NOP inside the register-ALU class
  localparam logic [5:0] OP_NOP = 6'b000000;

  // ALU operation encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_SHR = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Accumulator operation encodings; 101..111 are reserved
  localparam logic [2:0] ACC_HOLD  = 3'b000;
  localparam logic [2:0] ACC_LOAD  = 3'b001;
  localparam logic [2:0] ACC_ADD   = 3'b010;
  localparam logic [2:0] ACC_SUB   = 3'b011;
  localparam logic [2:0] ACC_CLEAR = 3'b100;

  // Control bundle handed from the decoder to the output register
  typedef struct packed {
    logic       mem_to_reg;
    logic       mem_write;
    logic       pc_src;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic [2:0] alu_ctrl;
    logic [2:0] acc_ctrl;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/controller_decode.sv
// Combinational opcode decoder: maps op class/function plus the branch
// condition onto the datapath control bundle. Unlisted fields stay 0.
module controller_decode
  import controller_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic       branch_flag_i,
  output ctrl_t      ctrl_o
);

  logic [2:0] cls;
  logic [2:0] fn;

  assign cls = op_i[5:3];
  assign fn  = op_i[2:0];

  // Class-based decode; reserved class and anything undecodable fall to NOP
  always_comb begin
    ctrl_o = CTRL_NOP;
    case (cls)
      CLS_RALU: begin
        if (op_i != OP_NOP) begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_src   = 1'b0;
          ctrl_o.alu_ctrl  = fn;
        end
      end
      CLS_IALU: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_ctrl  = fn;
      end
      CLS_BR: begin
        // The function field selects the compare; the datapath flag decides
        ctrl_o.alu_ctrl = fn;
        ctrl_o.pc_src   = branch_flag_i;
      end
      CLS_ACC: begin
        ctrl_o.acc_ctrl = fn;
        ctrl_o.alu_ctrl = ALU_ADD;
      end
      CLS_LD: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.alu_ctrl   = ALU_ADD;
      end
      CLS_ST: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_ctrl  = ALU_ADD;
      end
      CLS_JMP: begin
        // Unconditional: the branch flag is deliberately ignored here
        ctrl_o.jump = 1'b1;
      end
      default: ctrl_o = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/controller_unit.sv
// Main control unit: decodes op/BranchFlag and registers the control strobes
// so they line up with the execute stage one cycle later.
module controller_unit
  import controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       BranchFlag,
  output logic       MemToReg,
  output logic       MemWrite,
  output logic       PcSrc,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       Jump,
  output logic [2:0] ALUControl,
  output logic [2:0] AccControl
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  controller_decode u_decode (
    .op_i          (op),
    .branch_flag_i (BranchFlag),
    .ctrl_o        (ctrl_d)
  );

  // Decode -> execute stage register; async clear forces every strobe low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_NOP;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign MemToReg   = ctrl_q.mem_to_reg;
  assign MemWrite   = ctrl_q.mem_write;
  assign PcSrc      = ctrl_q.pc_src;
  assign ALUSrc     = ctrl_q.alu_src;
  assign RegWrite   = ctrl_q.reg_write;
  assign Jump       = ctrl_q.jump;
  assign ALUControl = ctrl_q.alu_ctrl;
  assign AccControl = ctrl_q.acc_ctrl;

endmodule

// File: tb/tb_controller_unit.sv
// Scoreboard bench for controller_unit. Stimulus pushes the expected control
// word when it drives op/BranchFlag; the monitor pops and compares one edge
// later. Word layout: {MemToReg,MemWrite,PcSrc,ALUSrc,RegWrite,Jump,ALU[2:0],ACC[2:0]}.
module tb_controller_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       BranchFlag;
  logic       MemToReg;
  logic       MemWrite;
  logic       PcSrc;
  logic       ALUSrc;
  logic       RegWrite;
  logic       Jump;
  logic [2:0] ALUControl;
  logic [2:0] AccControl;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [11:0] exp;
    string       name;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  controller_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .BranchFlag (BranchFlag),
    .MemToReg   (MemToReg),
    .MemWrite   (MemWrite),
    .PcSrc      (PcSrc),
    .ALUSrc     (ALUSrc),
    .RegWrite   (RegWrite),
    .Jump       (Jump),
    .ALUControl (ALUControl),
    .AccControl (AccControl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] actual_word();
    return {MemToReg, MemWrite, PcSrc, ALUSrc, RegWrite, Jump, ALUControl, AccControl};
  endfunction

  // Reference decode written from the instruction-class table
  function automatic logic [11:0] ref_decode(input logic [5:0] o, input logic bf);
    int cls;
    int fn;
    logic m2r, mw, pcs, asrc, rw, j;
    logic [2:0] alu, acc;
    cls = int'(o) / 8;
    fn  = int'(o) % 8;
    {m2r, mw, pcs, asrc, rw, j} = '0;
    alu = 3'd0;
    acc = 3'd0;
    if (cls == 0 && fn != 0) begin rw = 1; alu = 3'(fn); end
    else if (cls == 1) begin rw = 1; asrc = 1; alu = 3'(fn); end
    else if (cls == 2) begin alu = 3'(fn); pcs = bf; end
    else if (cls == 3) begin acc = 3'(fn); end
    else if (cls == 4) begin m2r = 1; rw = 1; asrc = 1; end
    else if (cls == 5) begin mw = 1; asrc = 1; end
    else if (cls == 7) begin j = 1; end
    return {m2r, mw, pcs, asrc, rw, j, alu, acc};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %03h expected %03h", name, act, exp);
    end
  endtask

  // Drive on the falling edge; the response is due after the next rising edge
  task automatic issue(input logic [5:0] o, input logic bf, input logic [11:0] exp, input string name);
    sb_entry_t e;
    @(negedge clk);
    op = o;
    BranchFlag = bf;
    e.exp = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Monitor: compare queued expectation and invariants after every rising edge
  initial begin
    sb_entry_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check(e.name, actual_word(), e.exp);
        end
        checks++;
        if (Jump && PcSrc) begin
          failures++;
          $display("FAIL inv_jump_pcsrc: Jump=%0b PcSrc=%0b required not both 1", Jump, PcSrc);
        end
        checks++;
        if (MemWrite && RegWrite) begin
          failures++;
          $display("FAIL inv_memwrite_regwrite: MemWrite=%0b RegWrite=%0b required RegWrite=0", MemWrite, RegWrite);
        end
        checks++;
        if (MemToReg && !RegWrite) begin
          failures++;
          $display("FAIL inv_memtoreg_regwrite: MemToReg=%0b RegWrite=%0b required RegWrite=1", MemToReg, RegWrite);
        end
      end
    end
  end

  initial begin
    logic [5:0] ro;
    logic       rb;
    rst_n = 1'b0;
    op = 6'b001000;
    BranchFlag = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_held", actual_word(), 12'h000);

    // Release reset, first decode after the next edge
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_release_no_edge", actual_word(), 12'h000);
    issue(6'b001000, 1'b0, 12'h188 - 12'h008, "ialu_add");

    issue(6'b000000, 1'b0, 12'h000, "nop");
    issue(6'b001001, 1'b0, 12'h188, "ialu_sub");
    issue(6'b001010, 1'b0, 12'h190, "ialu_and");
    issue(6'b000011, 1'b1, 12'h098, "ralu_or");
    issue(6'b010001, 1'b1, 12'h208, "branch_taken");
    issue(6'b010001, 1'b0, 12'h008, "branch_not_taken");
    issue(6'b100101, 1'b1, 12'h980, "load");
    issue(6'b101000, 1'b0, 12'h500, "store");
    issue(6'b111001, 1'b1, 12'h040, "jump_flag_ignored");
    issue(6'b011010, 1'b0, 12'h002, "acc_add");
    issue(6'b110011, 1'b1, 12'h000, "reserved");

    // Random op/BranchFlag every cycle against the reference decode
    for (int i = 0; i < 400; i++) begin
      ro = 6'($urandom_range(0, 63));
      rb = 1'($urandom_range(0, 1));
      issue(ro, rb, ref_decode(ro, rb), "random");
    end

    // Drain, then assert reset mid-cycle while a nonzero decode is visible
    @(negedge clk);
    op = 6'b001000;
    BranchFlag = 1'b0;
    @(posedge clk);
    #1 check("pre_async_reset", actual_word(), 12'h180);
    #2 rst_n = 1'b0;
    #1 check("async_reset_immediate", actual_word(), 12'h000);
    @(posedge clk);
    #1 check("async_reset_hold", actual_word(), 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("async_release_no_edge", actual_word(), 12'h000);
    issue(6'b001000, 1'b0, 12'h180, "post_reset_ialu");
    issue(6'b011100, 1'b1, 12'h004, "acc_clear");

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controller_unit.md
Name: controller_unit

Overview:
- Main control decoder for the accumulator-style CPU datapath.
- Decodes the 6-bit opcode plus the datapath branch condition into the datapath control strobes: mem/reg writeback select, memory write, PC source, ALU operand select, register write, jump, ALU op and accumulator op.
- Outputs are registered: one cycle of latency, aligned to the execute stage.

Parameters:
- None. Opcode width is fixed at 6 and the control-field widths are fixed at 3.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- op  input  6  instruction opcode; op[5:3] is the class, op[2:0] is the function
- BranchFlag  input  1  branch condition from the datapath (1 = condition true)
- MemToReg  output  1  writeback source select (1 = data memory, 0 = ALU)
- MemWrite  output  1  data-memory write enable
- PcSrc  output  1  take branch target (1 = branch target, 0 = PC+1)
- ALUSrc  output  1  ALU operand B select (1 = immediate, 0 = register)
- RegWrite  output  1  register-file write enable
- Jump  output  1  unconditional jump select
- ALUControl  output  3  ALU operation code
- AccControl  output  3  accumulator operation code (000 = hold)

Behaviour:
- Reset:
  - One clock (clk); reset is asynchronous and active-low (rst_n).
  - While rst_n=0, all outputs are 0 immediately, with no clock edge required.
  - Outputs stay 0 until the first rising clk edge after rst_n deasserts.
- Latency:
  - Outputs are registered on each rising clk edge from that edge's op and BranchFlag.
  - Latency is exactly 1 cycle; there is no other state.
- Decode, by op[5:3]; any field not listed is 0:
  - 000 (register ALU): RegWrite=1, ALUSrc=0, ALUControl=op[2:0]. Exception: op=000000 is NOP, with all outputs 0.
  - 001 (immediate ALU): RegWrite=1, ALUSrc=1, ALUControl=op[2:0].
  - 010 (conditional branch): ALUControl=op[2:0] (compare op), PcSrc=BranchFlag, RegWrite=0.
  - 011 (accumulator op): AccControl=op[2:0], ALUControl=000.
  - 100 (load): MemToReg=1, RegWrite=1, ALUSrc=1, ALUControl=000 (address add).
  - 101 (store): MemWrite=1, ALUSrc=1, ALUControl=000.
  - 110 (reserved): treated as NOP, all outputs 0.
  - 111 (jump): Jump=1, PcSrc=0; BranchFlag is ignored.
- BranchFlag affects only PcSrc, and only in class 010.
- Invariants that hold in every cycle:
  - Jump and PcSrc are never both 1.
  - MemWrite=1 implies RegWrite=0.
  - MemToReg=1 implies RegWrite=1.
- Any op bit that is X or Z is not required to decode to anything specific. Synthesis implements a full case with the NOP default.

Decomposition:
- Shared package controller_pkg holds:
  - the opcode class localparams: CLS_RALU, CLS_IALU, CLS_BR, CLS_ACC, CLS_LD, CLS_ST, CLS_RSV, CLS_JMP;
  - the NOP opcode constant;
  - the ALU op encodings: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr, 111 slt;
  - the accumulator op encodings: 000 hold, 001 load, 010 add, 011 sub, 100 clear, remaining codes reserved;
  - a packed struct for the control bundle.
- One combinational sub-module, controller_decode (op and BranchFlag in, control bundle out).
- controller_unit instantiates controller_decode and registers its bundle, with asynchronous clear on rst_n.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with op=001000 -> all outputs 0 immediately. Release rst_n, apply op=001000; after the next edge -> RegWrite=1, ALUSrc=1, ALUControl=000, all others 0.
- ALU sweep:
  - op=000000 -> all 0.
  - op=001001 -> RegWrite=1, ALUSrc=1, ALUControl=001.
  - op=001010 -> ALUControl=010, RegWrite=1, ALUSrc=1.
  - Each response is checked one cycle after op is applied.
- Branch: op=010001 with BranchFlag=1 -> PcSrc=1, ALUControl=001, RegWrite=0. Same op with BranchFlag=0 -> PcSrc=0.
- Memory:
  - op=100101 -> MemToReg=1, RegWrite=1, ALUSrc=1, ALUControl=000, MemWrite=0.
  - op=101000 -> MemWrite=1, ALUSrc=1, RegWrite=0.
- Jump/accumulator/reserved:
  - op=111001 with BranchFlag=1 -> Jump=1, PcSrc=0, all others 0.
  - op=011010 -> AccControl=010, RegWrite=0.
  - op=110011 -> all 0.
- Latency/invariants: change op every cycle with random op and BranchFlag. Check that each output equals the reference decode of the previous cycle's inputs, and that the three invariants hold in every cycle.
